// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the neural-network parameter path.
// Used by the loader, the network datapath and their benches.
package nn_pkg;

    typedef enum logic [2:0] {
        RG_W1    = 3'd0,
        RG_B1    = 3'd1,
        RG_W2    = 3'd2,
        RG_B2    = 3'd3,
        RG_INPUT = 3'd4
    } region_t;

    localparam int DEF_IN_SIZE  = 2;
    localparam int DEF_HIDDEN1  = 64;
    localparam int DEF_OUT_SIZE = 3;
    localparam int DEF_WIDTH    = 18;
    localparam int DEF_BATCH    = 300;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // An index range of n entries never collapses below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int word_count(input int i, input int h,
                                      input int o, input int b);
        return h * i + h + o * h + o + b * i;
    endfunction

    localparam int DEF_WORDS =
        word_count(DEF_IN_SIZE, DEF_HIDDEN1, DEF_OUT_SIZE, DEF_BATCH);
    localparam int DEF_ROW_W =
        idx_w(max3(DEF_HIDDEN1, DEF_OUT_SIZE, DEF_BATCH));
    localparam int DEF_COL_W =
        idx_w(max3(DEF_IN_SIZE, DEF_HIDDEN1, 1));

endpackage

// File: rtl/nn_index_counter.sv
// Row-major row/col walker; col runs fastest and the whole counter
// returns to zero after the last element of the region.
module nn_index_counter #(
    parameter int ROW_W = 9,
    parameter int COL_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [COL_W:0]   row_len,
    input  logic [ROW_W:0]   row_cnt,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             wrap,
    output logic             last
);

    assign wrap = ({1'b0, col} == row_len - 1'b1);
    assign last = wrap && ({1'b0, row} == row_cnt - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (wrap) begin
                row <= row + 1'b1;
                col <= '0;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_param_loader.sv
// Streams W1, B1, W2, B2 and the input batch into parameter memory,
// one registered write per accepted beat, with framing-error tracking.
module nn_param_loader
    import nn_pkg::*;
#(
    parameter  int IN_SIZE  = DEF_IN_SIZE,
    parameter  int HIDDEN1  = DEF_HIDDEN1,
    parameter  int OUT_SIZE = DEF_OUT_SIZE,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int BATCH    = DEF_BATCH,
    localparam int ROW_W    = idx_w(max3(HIDDEN1, OUT_SIZE, BATCH)),
    localparam int COL_W    = idx_w(max3(IN_SIZE, HIDDEN1, 1))
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    wr_en,
    output logic [2:0]              wr_sel,
    output logic [ROW_W-1:0]        wr_row,
    output logic [COL_W-1:0]        wr_col,
    output logic signed [WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE, LD_W1, LD_B1, LD_W2, LD_B2, LD_IN, FINISH
    } state_t;

    localparam logic [COL_W:0] LEN_IN  = (COL_W + 1)'(IN_SIZE);
    localparam logic [COL_W:0] LEN_H   = (COL_W + 1)'(HIDDEN1);
    localparam logic [COL_W:0] LEN_ONE = (COL_W + 1)'(1);
    localparam logic [ROW_W:0] CNT_H   = (ROW_W + 1)'(HIDDEN1);
    localparam logic [ROW_W:0] CNT_O   = (ROW_W + 1)'(OUT_SIZE);
    localparam logic [ROW_W:0] CNT_B   = (ROW_W + 1)'(BATCH);

    state_t           state, state_nxt, ld_nxt;
    region_t          region;
    logic [COL_W:0]   row_len;
    logic [ROW_W:0]   row_cnt;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             cnt_wrap, cnt_last;
    logic             ld, xfer, region_end, final_beat, early;

    assign ld         = (state inside {LD_W1, LD_B1, LD_W2, LD_B2, LD_IN});
    assign s_ready    = ld;
    assign busy       = (state != IDLE);
    // Abort wins over a same-cycle beat, which is then dropped.
    assign xfer       = s_valid && ld && !abort;
    assign region_end = cnt_wrap && cnt_last;
    assign final_beat = (state == LD_IN) && region_end;
    assign early      = xfer && s_last && !final_beat;

    nn_index_counter #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (xfer),
        .clr     (!ld || abort),
        .row_len (row_len),
        .row_cnt (row_cnt),
        .row     (cnt_row),
        .col     (cnt_col),
        .wrap    (cnt_wrap),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_nxt    = state;
        region    = RG_W1;
        row_len   = LEN_IN;
        row_cnt   = CNT_H;
        unique case (state)
            IDLE:   if (start) state_nxt = LD_W1;
            LD_W1:  ld_nxt = LD_B1;
            LD_B1: begin
                region  = RG_B1;
                row_len = LEN_ONE;
                ld_nxt  = LD_W2;
            end
            LD_W2: begin
                region  = RG_W2;
                row_len = LEN_H;
                row_cnt = CNT_O;
                ld_nxt  = LD_B2;
            end
            LD_B2: begin
                region  = RG_B2;
                row_len = LEN_ONE;
                row_cnt = CNT_O;
                ld_nxt  = LD_IN;
            end
            LD_IN: begin
                region  = RG_INPUT;
                row_cnt = CNT_B;
                ld_nxt  = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (ld) begin
            if (abort || early)            state_nxt = IDLE;
            else if (xfer && region_end)   state_nxt = ld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                wr_sel  <= region;
                wr_row  <= cnt_row;
                wr_col  <= cnt_col;
                wr_data <= s_data;
            end
            done <= (state == FINISH);
            // s_last must coincide exactly with the final beat.
            if (state == IDLE && start)         err <= 1'b0;
            else if (xfer && (s_last != final_beat)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nn_param_loader.sv
// Randomized bench: a word-index model of the load order is compared
// against the loader outputs every cycle, plus scenario-level totals.
module tb_nn_param_loader;
    import nn_pkg::*;

    localparam int I     = 2;
    localparam int H     = 64;
    localparam int O     = 3;
    localparam int W     = 18;
    localparam int B     = 300;
    localparam int TOTAL = H * I + H + O * H + O + B * I;
    localparam int RW    = 9;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          wr_en;
    logic [2:0]    wr_sel;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [W-1:0]  wr_data;
    logic          busy, done, err;

    nn_param_loader #(
        .IN_SIZE (I), .HIDDEN1 (H), .OUT_SIZE (O),
        .WIDTH (W), .BATCH (B)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
        .s_last (s_last), .wr_en (wr_en), .wr_sel (wr_sel),
        .wr_row (wr_row), .wr_col (wr_col), .wr_data (wr_data),
        .busy (busy), .done (done), .err (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Flat word number -> (region, row, col) following the load order.
    task automatic map_idx(input int k, output int sel, output int row,
                           output int col);
        int r;
        r = k;
        if (r < H * I) begin
            sel = 0; row = r / I; col = r % I; return;
        end
        r -= H * I;
        if (r < H) begin
            sel = 1; row = r; col = 0; return;
        end
        r -= H;
        if (r < O * H) begin
            sel = 2; row = r / H; col = r % H; return;
        end
        r -= O * H;
        if (r < O) begin
            sel = 3; row = r; col = 0; return;
        end
        r -= O;
        sel = 4; row = r / I; col = r % I;
    endtask

    bit           m_ready, m_fin, m_wr, m_done, m_err, m_took;
    int           m_k, m_sel, m_row, m_col;
    logic [W-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_fin = 0; m_wr = 0; m_done = 0; m_err = 0;
            m_took = 0; m_k = 0; m_sel = 0; m_row = 0; m_col = 0;
            m_data = '0;
        end else begin
            m_took = 0;
            m_wr   = 0;
            m_done = m_fin;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_ready) begin
                if (start) begin
                    m_ready = 1; m_k = 0; m_err = 0;
                end
            end else if (abort) begin
                m_ready = 0;
            end else if (s_valid) begin
                m_took = 1;
                m_wr   = 1;
                map_idx(m_k, m_sel, m_row, m_col);
                m_data = s_data;
                if (m_k == TOTAL - 1) begin
                    m_ready = 0; m_fin = 1;
                    if (!s_last) m_err = 1;
                end else if (s_last) begin
                    m_ready = 0; m_err = 1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    int wcount, dcount, cyc, l_cyc, d_cyc;
    int f_sel, f_row, f_col, l_sel, l_row, l_col;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("s_ready", 32'(s_ready), 32'(m_ready));
            chk("busy", 32'(busy), 32'(m_ready | m_fin));
            chk("wr_en", 32'(wr_en), 32'(m_wr));
            chk("wr_sel", 32'(wr_sel), m_sel);
            chk("wr_row", 32'(wr_row), m_row);
            chk("wr_col", 32'(wr_col), m_col);
            chk("wr_data", 32'(wr_data), 32'(m_data));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            if (wr_en) begin
                if (wcount == 0) begin
                    f_sel = 32'(wr_sel); f_row = 32'(wr_row); f_col = 32'(wr_col);
                end
                l_sel = 32'(wr_sel); l_row = 32'(wr_row); l_col = 32'(wr_col);
                l_cyc = cyc;
                wcount++;
            end
            if (done) begin
                d_cyc = cyc;
                dcount++;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_wr_sel"}, 32'(wr_sel), 0);
        chk({tag, "_wr_row"}, 32'(wr_row), 0);
        chk({tag, "_wr_col"}, 32'(wr_col), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    task automatic run_load(input int gap_max, input int last_beat,
                            input int abort_beat, input int rst_beat,
                            input int start_beat, input bit final_last);
        int  beats = 0;
        int  gap = 0;
        int  n = 0;
        bit  over = 0;
        wcount = 0; dcount = 0; l_cyc = 0; d_cyc = 0;
        f_sel = -1; f_row = -1; f_col = -1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        while (!over) begin
            if (beats == rst_beat) begin
                @(negedge clk); #1;
                rst_n = 0;
                #1;
                chk_zero("rst_mid");
                s_valid = 0; s_last = 0; abort = 0; start = 0;
                @(posedge clk); #1;
                rst_n = 1;
                over = 1;
            end else begin
                abort = (beats == abort_beat);
                start = (beats == start_beat);
                if (gap > 0) begin
                    s_valid = 0;
                    s_last  = 0;
                    gap--;
                end else begin
                    s_valid = 1;
                    s_data  = W'($urandom);
                    s_last  = (beats + 1 == last_beat) ||
                              (final_last && beats + 1 == TOTAL);
                end
                @(posedge clk); #1;
                start = 0;
                if (m_took) begin
                    beats++;
                    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                end
                if (!m_ready) over = 1;
                n++;
                if (n > 20000) begin
                    checks++; errors++;
                    $display("FAIL timeout: beats %0d required %0d", beats, TOTAL);
                    over = 1;
                end
            end
        end
        s_valid = 0; s_last = 0; abort = 0; start = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic full_checks(input string tag, input int exp_err);
        chk({tag, "_writes"}, wcount, TOTAL);
        chk({tag, "_done_cnt"}, dcount, 1);
        chk({tag, "_err"}, 32'(err), exp_err);
        chk({tag, "_first_sel"}, f_sel, 0);
        chk({tag, "_first_row"}, f_row, 0);
        chk({tag, "_first_col"}, f_col, 0);
        chk({tag, "_last_sel"}, l_sel, 4);
        chk({tag, "_last_row"}, l_row, 299);
        chk({tag, "_last_col"}, l_col, 1);
        chk({tag, "_done_lag"}, d_cyc - l_cyc, 1);
    endtask

    initial begin
        int s, r, c;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");

        map_idx(0, s, r, c);
        chk("map0", s * 1000000 + r * 1000 + c, 0);
        map_idx(129, s, r, c);
        chk("map129", s * 1000000 + r * 1000 + c, 1001000);
        map_idx(192, s, r, c);
        chk("map192", s * 1000000 + r * 1000 + c, 2000000);
        map_idx(385, s, r, c);
        chk("map385", s * 1000000 + r * 1000 + c, 3001000);
        map_idx(TOTAL - 1, s, r, c);
        chk("map986", s * 1000000 + r * 1000 + c, 4299001);

        rst_n = 1;
        @(posedge clk); #1;

        run_load(0, -1, -1, -1, -1, 1);
        full_checks("full", 0);

        run_load(3, -1, -1, -1, -1, 1);
        full_checks("gaps", 0);

        run_load(0, 130, -1, -1, -1, 1);
        chk("early_writes", wcount, 130);
        chk("early_err", 32'(err), 1);
        chk("early_done", dcount, 0);
        chk("early_ready", 32'(s_ready), 0);
        chk("early_busy", 32'(busy), 0);

        run_load(2, -1, -1, -1, -1, 0);
        full_checks("nolast", 1);

        run_load(0, -1, 500, -1, -1, 1);
        chk("abort_writes", wcount, 500);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_done", dcount, 0);

        run_load(1, -1, -1, -1, -1, 1);
        full_checks("reload", 0);

        run_load(0, -1, -1, 200, -1, 1);
        chk("rst_writes", wcount, 200);
        run_load(0, -1, -1, -1, -1, 1);
        full_checks("post_rst", 0);

        run_load(0, -1, -1, -1, 50, 1);
        full_checks("restart", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_param_loader.md
NN_PARAM_LOADER -- requirements
Module: nn_param_loader

Interface
REQ-001 IN_SIZE, default 2, input features per sample.
REQ-002 HIDDEN1, default 64, hidden-layer neurons.
REQ-003 OUT_SIZE, default 3, output classes.
REQ-004 WIDTH, default 18, signed fixed-point word width.
REQ-005 BATCH, default 300, samples per load.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle pulse, begins a load.
REQ-009 abort  in  1  cancels a load in progress.
REQ-010 s_valid  in  1  stream beat valid.
REQ-011 s_ready  out  1  loader accepts a beat.
REQ-012 s_data  in  WIDTH  signed fixed-point word, FRAC already applied by the producer.
REQ-013 s_last  in  1  producer marks its final beat.
REQ-014 wr_en  out  1  parameter-memory write strobe.
REQ-015 wr_sel  out  3  target region: region_t (W1, B1, W2, B2, INPUT).
REQ-016 wr_row  out  clog2(max(HIDDEN1,OUT_SIZE,BATCH))  row index.
REQ-017 wr_col  out  clog2(max(IN_SIZE,HIDDEN1))  column index, 0 for biases.
REQ-018 wr_data  out  WIDTH  word to write.
REQ-019 busy  out  1  load in progress.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  1  sticky framing error, cleared by next accepted start.

Function
REQ-022 FSM states: IDLE, LD_W1, LD_B1, LD_W2, LD_B2, LD_IN, FINISH.
REQ-023 IDLE -> LD_W1 on start; start outside IDLE is ignored.
REQ-024 s_ready = 1 in every LD_* state, 0 in IDLE and FINISH; a beat transfers when s_valid && s_ready.
REQ-025 Order: W1 [HIDDEN1][IN_SIZE], B1 [HIDDEN1], W2 [OUT_SIZE][HIDDEN1], B2 [OUT_SIZE], inputs [BATCH][IN_SIZE]; row-major, col increments fastest.
REQ-026 Col wraps to 0 at row length and row increments; at the last row/col of a region, counters clear and FSM advances to the next region on the same transfer.
REQ-027 Each transfer produces wr_en=1 exactly one cycle later with the registered wr_sel/wr_row/wr_col/wr_data; no write without a transfer.
REQ-028 Stall (s_valid=0) holds counters and state; wr_en=0 that cycle.
REQ-029 Transfer of the final input word (row BATCH-1, col IN_SIZE-1) -> FINISH; FINISH lasts one cycle, asserts done, then -> IDLE.
REQ-030 s_last on a non-final transfer: the word is still written, err=1, FSM -> IDLE with no done.
REQ-031 Final transfer without s_last: err=1, done still pulses.
REQ-032 abort in any LD_* state: -> IDLE next cycle, a transfer in the same cycle is discarded (no write), err unchanged, no done.
REQ-033 busy = 1 in LD_* and FINISH.
REQ-034 Total words per load = HIDDEN1*IN_SIZE + HIDDEN1 + OUT_SIZE*HIDDEN1 + OUT_SIZE + BATCH*IN_SIZE (987 at defaults).
REQ-035 Data passes unmodified; no saturation or rounding.

Reset
REQ-036 rst_n low: state IDLE, counters 0, s_ready/wr_en/busy/done/err 0, wr_sel/wr_row/wr_col/wr_data 0.
REQ-037 Reset mid-load discards the partial load; memory contents are not cleared by this block.

Structure
REQ-038 Package nn_pkg holds region_t enum and the word-count and index-width localparams shared with the network and its benches.
REQ-039 One sub-module nn_index_counter: parameterized row/col counter with enable, clear, row-length/row-count inputs, wrap and last outputs.

Verification
REQ-040 Full load at defaults, s_valid held 1 -> 987 writes, first write W1[0][0], last INPUT[299][1], done one cycle after the last write, err=0.
REQ-041 Random s_valid gaps of 0-3 cycles -> identical write sequence and contents, no write during gaps.
REQ-042 s_last on beat 130 (B1 row 1) -> 130 writes, err=1, done never asserted, back in IDLE, s_ready=0.
REQ-043 abort at beat 500 with s_valid=1 -> 500 writes, busy=0 next cycle, err=0; following start reloads from W1[0][0].
REQ-044 rst_n asserted at beat 200 -> all outputs 0 immediately; start after release -> full correct load.
REQ-045 start pulsed at beat 50 -> ignored, load completes normally with 987 writes.
